// File: rtl/layer_sequencer.sv
// Network-level controller for the SA/ACC_POOL accelerator: steps through the fixed
// 5-layer LeNet schedule. Optional WAIT timeout enabled by defining SEQ_TIMEOUT_EN.
module layer_sequencer #(
  parameter int POOL_RST_CYC = 2,
  parameter int TIMEOUT_CYC  = 1_000_000,
  parameter int TO_W         = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run_i,
  input  logic        abort_i,
  input  logic [15:0] pool_last_i,
  input  logic        act_last_i,
  output logic [1:0]  start_o,
  output logic [1:0]  nth_o,
  output logic [4:0]  ofmap_size_o,
  output logic [5:0]  ifmap_ch_o,
  output logic [8:0]  in_node_num_o,
  output logic [6:0]  out_node_num_o,
  output logic        rst_pool_n_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [2:0]  layer_o
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_POOL_RST = 3'd1;
  localparam logic [2:0] S_LOAD     = 3'd2;
  localparam logic [2:0] S_START    = 3'd3;
  localparam logic [2:0] S_WAIT     = 3'd4;
  localparam logic [2:0] S_NEXT     = 3'd5;
  localparam logic [2:0] S_DONE     = 3'd6;
  localparam logic [2:0] S_ERR      = 3'd7;

  localparam int PC_W = (POOL_RST_CYC > 1) ? $clog2(POOL_RST_CYC) : 1;
  localparam logic [PC_W-1:0] PC_LAST = PC_W'(POOL_RST_CYC - 1);

  if (POOL_RST_CYC < 1 || TIMEOUT_CYC < 1 || TO_W < 1 || TO_W > 30 ||
      TIMEOUT_CYC >= (1 << TO_W)) begin : g_bad_params
    $error("layer_sequencer: invalid parameter set");
  end

  logic [2:0]      state;
  logic [PC_W-1:0] pool_cnt;
  logic [15:0]     mask;
  logic [15:0]     mask_nxt;
  logic            conv_layer;
  logic            wait_done;
  logic            idle_like;
  logic            to_hit;

  // Pool-complete flags accumulate; a layer ends the cycle the last missing bit shows up.
  assign mask_nxt   = mask | pool_last_i;
  assign conv_layer = (layer_o < 3'd2);
  assign wait_done  = conv_layer ? (mask_nxt == 16'hFFFF) : act_last_i;
  assign idle_like  = (state == S_IDLE) || (state == S_DONE) || (state == S_ERR);

`ifdef SEQ_TIMEOUT_EN
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  logic [TO_W-1:0] to_cnt;
  logic            err_q;

  assign to_hit = (to_cnt == TO_LAST);
  assign err_o  = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt <= '0;
      err_q  <= 1'b0;
    end else if (abort_i) begin
      to_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state == S_START)
        to_cnt <= '0;
      else if (state == S_WAIT)
        to_cnt <= to_cnt + 1'b1;
      if (state == S_WAIT && !wait_done && to_hit)
        err_q <= 1'b1;
      else if (idle_like && run_i)
        err_q <= 1'b0;
    end
  end
`else
  assign to_hit = 1'b0;
  assign err_o  = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      pool_cnt       <= '0;
      mask           <= '0;
      start_o        <= 2'd0;
      nth_o          <= 2'd0;
      ofmap_size_o   <= '0;
      ifmap_ch_o     <= '0;
      in_node_num_o  <= '0;
      out_node_num_o <= '0;
      rst_pool_n_o   <= 1'b1;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
      layer_o        <= 3'd0;
    end else if (abort_i) begin
      state          <= S_IDLE;
      pool_cnt       <= '0;
      mask           <= '0;
      start_o        <= 2'd0;
      nth_o          <= 2'd0;
      ofmap_size_o   <= '0;
      ifmap_ch_o     <= '0;
      in_node_num_o  <= '0;
      out_node_num_o <= '0;
      rst_pool_n_o   <= 1'b1;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
      layer_o        <= 3'd0;
    end else if (idle_like) begin
      done_o <= 1'b0;
      if (run_i) begin
        layer_o      <= 3'd0;
        pool_cnt     <= '0;
        rst_pool_n_o <= 1'b0;
        busy_o       <= 1'b1;
        state        <= S_POOL_RST;
      end
    end else begin
      case (state)
        S_POOL_RST: begin
          if (pool_cnt == PC_LAST) begin
            rst_pool_n_o <= 1'b1;
            state        <= S_LOAD;
          end else begin
            pool_cnt <= pool_cnt + 1'b1;
          end
        end
        // Fields that don't apply to the layer kind are zeroed.
        S_LOAD: begin
          mask    <= '0;
          start_o <= conv_layer ? 2'd1 : 2'd2;
          state   <= S_START;
          case (layer_o)
            3'd0: begin
              nth_o <= 2'd0; ofmap_size_o <= 5'd28; ifmap_ch_o <= 6'd1;
              in_node_num_o <= 9'd0; out_node_num_o <= 7'd0;
            end
            3'd1: begin
              nth_o <= 2'd1; ofmap_size_o <= 5'd10; ifmap_ch_o <= 6'd6;
              in_node_num_o <= 9'd0; out_node_num_o <= 7'd0;
            end
            3'd2: begin
              nth_o <= 2'd0; ofmap_size_o <= 5'd0; ifmap_ch_o <= 6'd0;
              in_node_num_o <= 9'd400; out_node_num_o <= 7'd120;
            end
            3'd3: begin
              nth_o <= 2'd1; ofmap_size_o <= 5'd0; ifmap_ch_o <= 6'd0;
              in_node_num_o <= 9'd120; out_node_num_o <= 7'd84;
            end
            default: begin
              nth_o <= 2'd2; ofmap_size_o <= 5'd0; ifmap_ch_o <= 6'd0;
              in_node_num_o <= 9'd84; out_node_num_o <= 7'd10;
            end
          endcase
        end
        S_START: begin
          start_o <= 2'd0;
          state   <= S_WAIT;
        end
        S_WAIT: begin
          if (conv_layer)
            mask <= mask_nxt;
          if (wait_done) begin
            state <= S_NEXT;
          end else if (to_hit) begin
            busy_o <= 1'b0;
            state  <= S_ERR;
          end
        end
        S_NEXT: begin
          if (layer_o == 3'd4) begin
            done_o <= 1'b1;
            busy_o <= 1'b0;
            state  <= S_DONE;
          end else begin
            layer_o <= layer_o + 3'd1;
            if ((layer_o + 3'd1) < 3'd2) begin
              rst_pool_n_o <= 1'b0;
              pool_cnt     <= '0;
              state        <= S_POOL_RST;
            end else begin
              state <= S_LOAD;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
